// File: rtl/mp1000_cart_loader.sv
// Purpose: captures the OSD cartridge download into on-chip ROM, sizes it, derives a mirror mask, serves CPU reads.
// Latency: byte writes commit on the strobe edge; CPU reads are registered, 1 cycle addr->data.
// Backpressure: none; the ioctl stream is accepted every cycle, the core is held in reset via core_hold instead.
//
// Ports:
//   clk_sys, reset                  : only clock, synchronous active-high power-on reset
//   ioctl_download/index/wr/addr/dout : hps_io download bus
//   cpu_addr -> cpu_dout            : mirrored cartridge read port (8'hFF when no cartridge)
//   cart_loaded/size/mask/overflow  : image status
//   core_hold                       : high while loading or computing the mask; OR into core reset
module mp1000_cart_loader #(
    parameter int ADDR_W     = 13,
    parameter int CART_INDEX = 1
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [7:0]        cpu_dout,
    output logic              cart_loaded,
    output logic [ADDR_W:0]   cart_size,
    output logic [ADDR_W-1:0] cart_mask,
    output logic              cart_overflow,
    output logic              core_hold
);

    localparam int unsigned   DEPTH    = 1 << ADDR_W;
    localparam logic [5:0]    CART_IDX = CART_INDEX[5:0];

    typedef enum logic [1:0] {IDLE, LOAD, FINISH, READY} state_t;

    state_t            state;
    logic              dl_q;
    logic [7:0]        mem [DEPTH];

    logic              sel;
    logic              start;
    logic              wr_acc;
    logic              in_range;
    logic [ADDR_W:0]   wr_size;
    logic [ADDR_W:0]   mask_inc;
    logic [ADDR_W:0]   size_nxt;
    logic              ovf_nxt;

    // Index bits [7:6] carry hps_io flags that have no meaning here.
    logic              unused_idx_bits;
    assign unused_idx_bits = &{1'b0, ioctl_index[7:6]};

    assign sel      = ioctl_download && (ioctl_index[5:0] == CART_IDX);
    assign start    = sel && !dl_q && ((state == IDLE) || (state == READY));
    // A strobe on the very first download cycle (the start cycle) must land too.
    // Outside LOAD/start the stream is ignored, e.g. the tail of a download
    // that was interrupted by reset.
    assign wr_acc   = sel && ioctl_wr && !reset && ((state == LOAD) || start);
    assign in_range = ioctl_addr < 25'(DEPTH);
    assign wr_size  = {1'b0, ioctl_addr[ADDR_W-1:0]} + {{ADDR_W{1'b0}}, 1'b1};
    assign mask_inc = {1'b0, cart_mask} + {{ADDR_W{1'b0}}, 1'b1};

    // Size/overflow bookkeeping; the start cycle clears the old image's
    // status and may accumulate its own first byte in the same edge.
    always_comb begin
        size_nxt = start ? '0 : cart_size;
        ovf_nxt  = start ? 1'b0 : cart_overflow;
        if (wr_acc) begin
            if (in_range) begin
                if (wr_size > size_nxt) begin
                    size_nxt = wr_size;
                end
            end else begin
                ovf_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        // dl_q keeps tracking sel through reset so an ongoing download is not
        // mistaken for a fresh one once reset drops.
        dl_q <= sel;
        if (reset) begin
            state         <= IDLE;
            cart_loaded   <= 1'b0;
            cart_size     <= '0;
            cart_mask     <= '0;
            cart_overflow <= 1'b0;
            core_hold     <= 1'b0;
        end else begin
            cart_size     <= size_nxt;
            cart_overflow <= ovf_nxt;
            case (state)
                IDLE, READY: begin
                    if (start) begin
                        state       <= LOAD;
                        core_hold   <= 1'b1;
                        cart_loaded <= 1'b0;
                        cart_mask   <= '0;
                    end
                end
                LOAD: begin
                    if (!sel && dl_q) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    // Grow the mask one bit per cycle until it covers the image.
                    if (mask_inc < cart_size) begin
                        cart_mask <= {cart_mask[ADDR_W-2:0], 1'b1};
                    end else if (cart_size != '0) begin
                        state       <= READY;
                        cart_loaded <= 1'b1;
                        core_hold   <= 1'b0;
                    end else begin
                        state     <= IDLE;
                        core_hold <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    core_hold <= 1'b0;
                end
            endcase
        end
    end

    // Cartridge ROM contents survive reset and reloads; never cleared.
    always_ff @(posedge clk_sys) begin
        if (wr_acc && in_range) begin
            mem[ioctl_addr[ADDR_W-1:0]] <= ioctl_dout;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cpu_dout <= 8'hFF;
        end else begin
            cpu_dout <= cart_loaded ? mem[cpu_addr & cart_mask] : 8'hFF;
        end
    end

endmodule

// File: tb/tb_mp1000_cart_loader.sv
module tb_mp1000_cart_loader;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [12:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cart_loaded;
    logic [13:0] cart_size;
    logic [12:0] cart_mask;
    logic        cart_overflow;
    logic        core_hold;

    mp1000_cart_loader #(.ADDR_W(13), .CART_INDEX(1)) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .cpu_addr       (cpu_addr),
        .cpu_dout       (cpu_dout),
        .cart_loaded    (cart_loaded),
        .cart_size      (cart_size),
        .cart_mask      (cart_mask),
        .cart_overflow  (cart_overflow),
        .core_hold      (core_hold)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: cartridge contents and status, from the loading rules.
    logic [7:0] ref_mem [8192];
    int         m_size, m_mask, m_fin;
    bit         m_ovf, m_loaded;

    int          wr_addr_q [$];
    logic [7:0]  wr_data_q [$];

    typedef struct {
        logic [7:0] idx;
        int         n;
        logic [7:0] key;
        int         exp_size;
        int         exp_mask;
        bit         exp_loaded;
        bit         exp_ovf;
        int         exp_fin;
    } vec_t;

    vec_t vecs [6];

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] dat_fn(input int a, input logic [7:0] key);
        return (a[7:0] ^ key) + a[15:8];
    endfunction

    task automatic model_begin;
        m_size = 0; m_ovf = 0; m_loaded = 0; m_mask = 0;
    endtask

    task automatic model_write(input int a, input logic [7:0] d);
        if (a < 8192) begin
            ref_mem[a] = d;
            if (a + 1 > m_size) m_size = a + 1;
        end else begin
            m_ovf = 1;
        end
    endtask

    task automatic model_end;
        int k;
        k = 0;
        while ((1 << k) < m_size) k++;
        m_mask   = (1 << k) - 1;
        m_loaded = (m_size != 0);
        m_fin    = k + 1;
    endtask

    task automatic fill_seq(input int n, input logic [7:0] key);
        wr_addr_q.delete();
        wr_data_q.delete();
        for (int a = 0; a < n; a++) begin
            wr_addr_q.push_back(a);
            wr_data_q.push_back(dat_fn(a, key));
        end
    endtask

    // Drives one download from the queues, then waits for the mask computation.
    task automatic run_download(input logic [7:0] idx, input bit gaps,
                                output int fin, output bit hold_seen,
                                output bit first_hold, output int size1);
        bit match;
        match      = (idx[5:0] == 6'd1);
        fin        = 0;
        hold_seen  = 0;
        size1      = -1;
        if (match) model_begin();
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        if (wr_addr_q.size() == 0) begin
            tick; first_hold = core_hold; hold_seen |= core_hold;
            tick; hold_seen |= core_hold;
        end
        for (int i = 0; i < wr_addr_q.size(); i++) begin
            ioctl_addr = 25'(wr_addr_q[i]);
            ioctl_dout = wr_data_q[i];
            ioctl_wr   = 1'b1;
            if (match) model_write(wr_addr_q[i], wr_data_q[i]);
            tick;
            if (i == 0) begin
                first_hold = core_hold;
                size1      = int'(cart_size);
            end
            hold_seen |= core_hold;
            ioctl_wr = 1'b0;
            if (gaps && $urandom_range(0, 3) == 0) begin
                tick; hold_seen |= core_hold;
            end
        end
        ioctl_download = 1'b0;
        tick;
        if (match) begin
            while (core_hold && fin < 40) begin
                tick;
                fin++;
            end
            if (fin >= 40) check("finish_timeout", 1, 0);
            model_end();
        end
    endtask

    task automatic read_check(input string name, input int a);
        int exp;
        cpu_addr = 13'(a);
        tick;
        exp = m_loaded ? int'(ref_mem[a & m_mask]) : 8'hFF;
        check(name, int'(cpu_dout), exp);
    endtask

    task automatic status_check(input string tag);
        check({tag, "_size"},   int'(cart_size),     m_size);
        check({tag, "_mask"},   int'(cart_mask),     m_mask);
        check({tag, "_loaded"}, int'(cart_loaded),   int'(m_loaded));
        check({tag, "_ovf"},    int'(cart_overflow), int'(m_ovf));
        check({tag, "_hold"},   int'(core_hold),     0);
    endtask

    initial begin
        int  fin, size1;
        bit  hold_seen, first_hold;
        logic [7:0] idx;

        vecs[0] = '{8'h01, 4096, 8'h5A, 4096, 13'h0FFF, 1'b1, 1'b0, 13};
        vecs[1] = '{8'h01, 2049, 8'h21, 2049, 13'h0FFF, 1'b1, 1'b0, 13};
        vecs[2] = '{8'h01, 9216, 8'h96, 8192, 13'h1FFF, 1'b1, 1'b1, 14};
        vecs[3] = '{8'h01, 1,    8'hC7, 1,    13'h0000, 1'b1, 1'b0, 1};
        vecs[4] = '{8'h41, 3,    8'h18, 3,    13'h0003, 1'b1, 1'b0, 3};
        vecs[5] = '{8'h01, 0,    8'h00, 0,    13'h0000, 1'b0, 1'b0, 1};

        reset = 1'b1; ioctl_download = 0; ioctl_index = 0; ioctl_wr = 0;
        ioctl_addr = 0; ioctl_dout = 0; cpu_addr = 0;
        model_begin();
        tick; tick;
        check("rst_dout",   int'(cpu_dout),      8'hFF);
        check("rst_loaded", int'(cart_loaded),   0);
        check("rst_size",   int'(cart_size),     0);
        check("rst_mask",   int'(cart_mask),     0);
        check("rst_ovf",    int'(cart_overflow), 0);
        check("rst_hold",   int'(core_hold),     0);
        reset = 1'b0;
        tick;
        check("idle_dout",  int'(cpu_dout),      8'hFF);

        // Table-driven downloads with sequential addresses.
        for (int i = 0; i < 6; i++) begin
            fill_seq(vecs[i].n, vecs[i].key);
            run_download(vecs[i].idx, i == 1, fin, hold_seen, first_hold, size1);
            check($sformatf("v%0d_first_hold", i), int'(first_hold), 1);
            if (vecs[i].n > 0) check($sformatf("v%0d_size_first", i), size1, 1);
            check($sformatf("v%0d_fin", i),    fin,                 vecs[i].exp_fin);
            check($sformatf("v%0d_size", i),   int'(cart_size),     vecs[i].exp_size);
            check($sformatf("v%0d_mask", i),   int'(cart_mask),     vecs[i].exp_mask);
            check($sformatf("v%0d_loaded", i), int'(cart_loaded),   int'(vecs[i].exp_loaded));
            check($sformatf("v%0d_ovf", i),    int'(cart_overflow), int'(vecs[i].exp_ovf));
            check($sformatf("v%0d_hold", i),   int'(core_hold),     0);
            if (i == 0) begin
                cpu_addr = 13'h1005;
                tick;
                check("img4k_rd1005", int'(cpu_dout), 8'h5F);
            end
            if (i == 1) begin
                cpu_addr = 13'h0800;
                tick;
                check("odd_rd0800", int'(cpu_dout), int'(dat_fn(2048, vecs[i].key)));
            end
            if (i == 2) begin
                for (int a = 0; a < 8192; a++) read_check($sformatf("ovf_rd%0h", a), a);
            end
            for (int r = 0; r < 24; r++) read_check($sformatf("v%0d_rd", i), $urandom_range(0, 8191));
        end

        // Wrong index while READY leaves everything alone.
        fill_seq(300, 8'h44);
        run_download(8'h01, 1'b0, fin, hold_seen, first_hold, size1);
        status_check("pre_wrong");
        fill_seq(200, 8'hC3);
        run_download(8'h02, 1'b0, fin, hold_seen, first_hold, size1);
        check("wrong_hold_seen", int'(hold_seen), 0);
        check("wrong_size",   int'(cart_size),   300);
        check("wrong_mask",   int'(cart_mask),   13'h01FF);
        check("wrong_loaded", int'(cart_loaded), 1);
        for (int a = 0; a < 300; a++) read_check("wrong_rd", a);

        // Reset in the middle of a download; the tail must be ignored.
        model_begin();
        ioctl_index = 8'h01; ioctl_download = 1'b1;
        for (int a = 0; a < 100; a++) begin
            ioctl_addr = 25'(a); ioctl_dout = dat_fn(a, 8'h33); ioctl_wr = 1'b1;
            model_write(a, dat_fn(a, 8'h33));
            tick;
        end
        reset = 1'b1; ioctl_addr = 25'd100; ioctl_dout = 8'hEE; ioctl_wr = 1'b1;
        tick;
        reset = 1'b0; ioctl_wr = 1'b0;
        model_begin();
        check("mrst_dout",   int'(cpu_dout),      8'hFF);
        check("mrst_loaded", int'(cart_loaded),   0);
        check("mrst_size",   int'(cart_size),     0);
        check("mrst_mask",   int'(cart_mask),     0);
        check("mrst_ovf",    int'(cart_overflow), 0);
        check("mrst_hold",   int'(core_hold),     0);
        hold_seen = 0;
        for (int a = 101; a < 200; a++) begin
            ioctl_addr = 25'(a); ioctl_dout = 8'hA5; ioctl_wr = 1'b1;
            tick;
            hold_seen |= core_hold;
        end
        ioctl_wr = 1'b0; ioctl_download = 1'b0;
        tick; tick; tick;
        check("tail_hold_seen", int'(hold_seen), 0);
        check("tail_size",   int'(cart_size),   0);
        check("tail_loaded", int'(cart_loaded), 0);
        read_check("tail_rd", 150);
        fill_seq(100, 8'h77);
        run_download(8'h01, 1'b0, fin, hold_seen, first_hold, size1);
        check("fresh_fin", fin, m_fin);
        status_check("fresh");
        for (int a = 0; a < 128; a++) read_check("fresh_rd", a);

        // Randomized downloads against the model.
        for (int it = 0; it < 10; it++) begin
            int lim, n;
            lim = $urandom_range(1, 9000);
            n   = $urandom_range(0, 400);
            wr_addr_q.delete();
            wr_data_q.delete();
            for (int j = 0; j < n; j++) begin
                wr_addr_q.push_back($urandom_range(0, lim - 1));
                wr_data_q.push_back(8'($urandom));
            end
            idx = {2'($urandom), ($urandom_range(0, 4) == 0) ? 6'd5 : 6'd1};
            run_download(idx, 1'b1, fin, hold_seen, first_hold, size1);
            if (idx[5:0] == 6'd1) check($sformatf("rnd%0d_fin", it), fin, m_fin);
            else check($sformatf("rnd%0d_hold_seen", it), int'(hold_seen), 0);
            status_check($sformatf("rnd%0d", it));
            for (int r = 0; r < 32; r++) read_check($sformatf("rnd%0d_rd", it), $urandom_range(0, 8191));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
